// File: rtl/axi_pkg.sv
// Shared AXI4 types for the memory-side responders: burst and response
// encodings, responder FSM states, beat width and burst legality check.
package axi_pkg;

  localparam int AXI_DATA_BYTES = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LAT   = 2'd1,
    ST_BURST = 2'd2
  } rd_state_e;

  // A burst is rejected as a whole (SLVERR on every beat) when its shape is
  // unsupported; only the low address bits matter for wrap alignment.
  function automatic logic burst_illegal(input logic [6:0] addr_lsb,
                                         input logic [7:0] len,
                                         input logic [2:0] size,
                                         input logic [1:0] burst);
    logic [7:0] step_m1;
    logic       misaligned;
    logic       wrap_len_ok;
    step_m1     = (8'd1 << size) - 8'd1;
    misaligned  = (({1'b0, addr_lsb} & step_m1) != 8'd0);
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    burst_illegal = (size > 3'd3) ||
                    (burst == BURST_RSVD) ||
                    ((burst == BURST_WRAP) && (!wrap_len_ok || misaligned));
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI4 burst address stepper (FIXED/INCR/WRAP), shared by the
// read responder and any future write responder.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_boundary;
  logic [ADDR_WIDTH-1:0] w_mask;

  always_comb begin
    w_step     = ADDR_WIDTH'(1) << i_size;
    w_incr     = i_addr + w_step;
    // Wrap window spans the whole burst: (len+1) beats of 2^size bytes.
    w_boundary = ADDR_WIDTH'({1'b0, i_len} + 9'd1) << i_size;
    w_mask     = w_boundary - ADDR_WIDTH'(1);
    unique case (i_burst)
      BURST_FIXED: o_next_addr = i_addr;
      BURST_WRAP:  o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
      default:     o_next_addr = w_incr;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read responder: one outstanding AR, FIXED/INCR/WRAP bursts served from a
// 64-bit word array with backdoor preload. Define AXI_RESP_STALL_EN for LFSR rvalid bubbles.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    MEM_WORDS    = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    READ_LATENCY = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  input  logic                         bd_wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_wr_index,
  input  logic [DATA_WIDTH-1:0]        bd_wr_data
);

  localparam int IDX_W      = $clog2(MEM_WORDS);
  localparam int LAT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int WORD_SHIFT = $clog2(AXI_DATA_BYTES);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * AXI_DATA_BYTES);

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  resp_e                 r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [7:0]            r_beat;
  logic [LAT_W-1:0]      r_lat_cnt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_slverr;

  logic                  w_ar_hs;
  logic                  w_first;
  logic                  w_adv;
  logic                  w_done;
  logic                  w_bubble;
  logic                  w_lat_hold;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_load_addr;
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  resp_e                 w_resp;
  logic [DATA_WIDTH-1:0] w_data;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  always_ff @(posedge clock) begin
    if (bd_wr_en) r_mem[bd_wr_index] <= bd_wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ar_hs     = 1'b0;
    w_first     = 1'b0;
    w_adv       = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s_axi_arvalid && r_arready) begin
          w_ar_hs     = 1'b1;
          w_state_nxt = ST_LAT;
        end
      end
      ST_LAT: begin
        if ((r_lat_cnt == '0) && !w_lat_hold) begin
          w_first     = 1'b1;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (r_rvalid && s_axi_rready) begin
          if (r_beat == r_len) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Beat lookup: the first beat reads the latched start address, later beats
  // read the stepped address that is about to become current.
  always_comb begin
    w_load_addr = w_adv ? w_next_addr : r_addr;
    w_off       = w_load_addr - BASE_ADDR;
    w_in_range  = (w_load_addr >= BASE_ADDR) && (w_off < MEM_BYTES);
    w_idx       = IDX_W'(w_off >> WORD_SHIFT);
    w_resp      = RESP_OKAY;
    w_data      = '0;
    if (r_slverr)        w_resp = RESP_SLVERR;
    else if (!w_in_range) w_resp = RESP_DECERR;
    else                 w_data = r_mem[w_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
      r_beat    <= '0;
      r_lat_cnt <= '0;
    end else begin
      r_arready <= (w_state_nxt == ST_IDLE);

      if (w_ar_hs)
        r_lat_cnt <= LAT_W'(READ_LATENCY - 1);
      else if ((r_state == ST_LAT) && (r_lat_cnt != '0))
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);

      if (w_ar_hs)    r_beat <= '0;
      else if (w_adv) r_beat <= r_beat + 8'd1;

      if (w_first || w_adv) begin
        r_rdata <= w_data;
        r_rresp <= w_resp;
        r_rlast <= w_first ? (r_len == 8'd0) : ((r_beat + 8'd1) == r_len);
      end else if (w_done) begin
        r_rlast <= 1'b0;
      end

      if (w_first)                 r_rvalid <= 1'b1;
      else if (w_done)             r_rvalid <= 1'b0;
      else if (w_adv)              r_rvalid <= !w_bubble;
      else if (r_state == ST_BURST) r_rvalid <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_ar_hs) begin
      r_addr   <= s_axi_araddr;
      r_len    <= s_axi_arlen;
      r_size   <= s_axi_arsize;
      r_burst  <= s_axi_arburst;
      r_slverr <= burst_illegal(s_axi_araddr[6:0], s_axi_arlen, s_axi_arsize, s_axi_arburst);
    end else if (w_adv) begin
      r_addr <= w_next_addr;
    end
  end

`ifdef AXI_RESP_STALL_EN
  logic [7:0] r_lfsr;
  logic       r_lat_gated;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr      <= 8'hA5;
      r_lat_gated <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      if (w_ar_hs)         r_lat_gated <= 1'b0;
      else if (w_lat_hold) r_lat_gated <= 1'b1;
    end
  end

  // Bubbles only follow a completed handshake, so rvalid never drops unacknowledged.
  assign w_bubble   = r_lfsr[0];
  assign w_lat_hold = (r_state == ST_LAT) && (r_lat_cnt == '0) && r_lfsr[0] && !r_lat_gated;
`else
  assign w_bubble   = 1'b0;
  assign w_lat_hold = 1'b0;
`endif

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: wrap ordering, stalls, decode errors,
// illegal wrap, mid-burst reset and back-to-back AR acceptance.
module tb_axi_read_responder;

  localparam int MEM_WORDS = 4096;
  localparam int IDXW      = $clog2(MEM_WORDS);

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            s_axi_arvalid = 1'b0;
  logic            s_axi_arready;
  logic [63:0]     s_axi_araddr = '0;
  logic [7:0]      s_axi_arlen = '0;
  logic [2:0]      s_axi_arsize = '0;
  logic [1:0]      s_axi_arburst = '0;
  logic            s_axi_rvalid;
  logic            s_axi_rready = 1'b0;
  logic [63:0]     s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast;
  logic            bd_wr_en = 1'b0;
  logic [IDXW-1:0] bd_wr_index = '0;
  logic [63:0]     bd_wr_data = '0;

  always #5 clock = ~clock;

  axi_read_responder #(
    .ADDR_WIDTH   (64),
    .DATA_WIDTH   (64),
    .MEM_WORDS    (MEM_WORDS),
    .BASE_ADDR    (64'h0),
    .READ_LATENCY (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .bd_wr_en      (bd_wr_en),
    .bd_wr_index   (bd_wr_index),
    .bd_wr_data    (bd_wr_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] got_data [16];
  logic [1:0]  got_resp [16];
  logic        got_last [16];
  int          got_n, first_cyc, unstable, ar_high;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bd_write(input int idx, input logic [63:0] d);
    bd_wr_en    = 1'b1;
    bd_wr_index = IDXW'(idx);
    bd_wr_data  = d;
    tick();
    bd_wr_en    = 1'b0;
  endtask

  task automatic do_ar(input logic [63:0] a, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] bt, output bit ok);
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = a;
    s_axi_arlen   = len;
    s_axi_arsize  = sz;
    s_axi_arburst = bt;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (s_axi_arready) ok = 1'b1;
      tick();
    end
    s_axi_arvalid = 1'b0;
  endtask

  // mode 0: rready held high; mode 1: rready pattern 1,0,0 repeating.
  task automatic collect(input int nbeats, input int mode);
    logic        held;
    logic [63:0] hd;
    logic        hl;
    logic [1:0]  hr;
    got_n = 0; first_cyc = -1; unstable = 0; ar_high = 0; held = 1'b0;
    hd = '0; hl = 1'b0; hr = '0;
    for (int cyc = 0; cyc < 300 && got_n < nbeats; cyc++) begin
      s_axi_rready = (mode == 0) || (cyc % 3 == 0);
      if (s_axi_arready) ar_high++;
      if (s_axi_rvalid && first_cyc < 0) first_cyc = cyc;
      if (held && (!s_axi_rvalid || s_axi_rdata !== hd || s_axi_rlast !== hl || s_axi_rresp !== hr))
        unstable++;
      held = 1'b0;
      if (s_axi_rvalid && s_axi_rready && got_n < 16) begin
        got_data[got_n] = s_axi_rdata;
        got_resp[got_n] = s_axi_rresp;
        got_last[got_n] = s_axi_rlast;
        got_n++;
      end else if (s_axi_rvalid) begin
        held = 1'b1; hd = s_axi_rdata; hl = s_axi_rlast; hr = s_axi_rresp;
      end
      tick();
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_tests++; if (s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL rst_arready: got %b expected 0", s_axi_arready); end
    n_tests++; if (s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b expected 0", s_axi_rvalid); end
    n_tests++; if (s_axi_rlast !== 1'b0) begin n_fail++; $display("FAIL rst_rlast: got %b expected 0", s_axi_rlast); end
    n_tests++; if (s_axi_rresp !== 2'd0) begin n_fail++; $display("FAIL rst_rresp: got %0d expected 0", s_axi_rresp); end
    n_tests++; if (s_axi_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", s_axi_rdata); end
    reset = 1'b0;
    tick();
    n_tests++; if (s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL rst_arready_after: got %b expected 1", s_axi_arready); end
  endtask

  task automatic test_wrap();
    int order [8] = '{5, 6, 7, 0, 1, 2, 3, 4};
    bit ok;
    for (int i = 0; i < 16; i++) bd_write(i, 64'(i) * 64'h1111);
    do_ar(64'h28, 8'd7, 3'd3, 2'd2, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wrap_ar_hs: got %b expected 1", ok); end
    collect(8, 0);
    n_tests++; if (first_cyc !== 2) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 2", first_cyc); end
    n_tests++; if (got_n !== 8) begin n_fail++; $display("FAIL wrap_beats: got %0d expected 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (got_data[i] !== 64'(order[i]) * 64'h1111) begin
        n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got_data[i], 64'(order[i]) * 64'h1111);
      end
      n_tests++; if (got_resp[i] !== 2'd0) begin n_fail++; $display("FAIL wrap_resp[%0d]: got %0d expected 0", i, got_resp[i]); end
      n_tests++; if (got_last[i] !== (i == 7)) begin n_fail++; $display("FAIL wrap_last[%0d]: got %b expected %b", i, got_last[i], (i == 7)); end
    end
    n_tests++; if (s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL wrap_rvalid_end: got %b expected 0", s_axi_rvalid); end
  endtask

  task automatic test_incr_stall();
    bit ok;
    do_ar(64'h10, 8'd3, 3'd3, 2'd1, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_ar_hs: got %b expected 1", ok); end
    collect(4, 1);
    n_tests++; if (got_n !== 4) begin n_fail++; $display("FAIL stall_beats: got %0d expected 4", got_n); end
    n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", unstable); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (got_data[i] !== 64'(i + 2) * 64'h1111) begin
        n_fail++; $display("FAIL stall_data[%0d]: got %h expected %h", i, got_data[i], 64'(i + 2) * 64'h1111);
      end
      n_tests++; if (got_last[i] !== (i == 3)) begin n_fail++; $display("FAIL stall_last[%0d]: got %b expected %b", i, got_last[i], (i == 3)); end
    end
  endtask

  task automatic test_decerr();
    bit ok;
    bd_write(MEM_WORDS - 1, 64'hDEAD_BEEF_CAFE_F00D);
    do_ar(64'(8 * MEM_WORDS - 8), 8'd1, 3'd3, 2'd1, ok);
    collect(2, 0);
    n_tests++; if (got_n !== 2) begin n_fail++; $display("FAIL dec_beats: got %0d expected 2", got_n); end
    n_tests++; if (got_data[0] !== 64'hDEAD_BEEF_CAFE_F00D) begin n_fail++; $display("FAIL dec_data0: got %h expected deadbeefcafef00d", got_data[0]); end
    n_tests++; if (got_resp[0] !== 2'd0) begin n_fail++; $display("FAIL dec_resp0: got %0d expected 0", got_resp[0]); end
    n_tests++; if (got_last[0] !== 1'b0) begin n_fail++; $display("FAIL dec_last0: got %b expected 0", got_last[0]); end
    n_tests++; if (got_data[1] !== 64'h0) begin n_fail++; $display("FAIL dec_data1: got %h expected 0", got_data[1]); end
    n_tests++; if (got_resp[1] !== 2'd3) begin n_fail++; $display("FAIL dec_resp1: got %0d expected 3", got_resp[1]); end
    n_tests++; if (got_last[1] !== 1'b1) begin n_fail++; $display("FAIL dec_last1: got %b expected 1", got_last[1]); end
  endtask

  task automatic test_bad_wrap();
    bit ok;
    do_ar(64'h0, 8'd2, 3'd3, 2'd2, ok);
    collect(3, 0);
    n_tests++; if (got_n !== 3) begin n_fail++; $display("FAIL badwrap_beats: got %0d expected 3", got_n); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (got_resp[i] !== 2'd2) begin n_fail++; $display("FAIL badwrap_resp[%0d]: got %0d expected 2", i, got_resp[i]); end
      n_tests++; if (got_data[i] !== 64'h0) begin n_fail++; $display("FAIL badwrap_data[%0d]: got %h expected 0", i, got_data[i]); end
      n_tests++; if (got_last[i] !== (i == 2)) begin n_fail++; $display("FAIL badwrap_last[%0d]: got %b expected %b", i, got_last[i], (i == 2)); end
    end
  endtask

  task automatic test_fixed();
    bit ok;
    do_ar(64'h20, 8'd2, 3'd3, 2'd0, ok);
    collect(3, 0);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (got_data[i] !== 64'h4444) begin n_fail++; $display("FAIL fixed_data[%0d]: got %h expected 4444", i, got_data[i]); end
      n_tests++; if (got_last[i] !== (i == 2)) begin n_fail++; $display("FAIL fixed_last[%0d]: got %b expected %b", i, got_last[i], (i == 2)); end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_ar(64'h0, 8'd7, 3'd3, 2'd1, ok);
    s_axi_rready = 1'b1;
    for (int i = 0; i < 10 && !s_axi_rvalid; i++) tick();
    n_tests++; if (s_axi_rvalid !== 1'b1) begin n_fail++; $display("FAIL mrst_first_rvalid: got %b expected 1", s_axi_rvalid); end
    tick();
    tick();
    n_tests++; if (s_axi_rdata !== 64'h2222) begin n_fail++; $display("FAIL mrst_beat2: got %h expected 2222", s_axi_rdata); end
    reset = 1'b1;
    s_axi_rready = 1'b0;
    tick();
    n_tests++; if (s_axi_rvalid !== 1'b0) begin n_fail++; $display("FAIL mrst_rvalid: got %b expected 0", s_axi_rvalid); end
    n_tests++; if (s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL mrst_arready: got %b expected 0", s_axi_arready); end
    reset = 1'b0;
    tick();
    n_tests++; if (s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL mrst_arready_after: got %b expected 1", s_axi_arready); end
    do_ar(64'h40, 8'd1, 3'd3, 2'd1, ok);
    collect(2, 0);
    n_tests++; if (got_data[0] !== 64'h8888) begin n_fail++; $display("FAIL mrst_new0: got %h expected 8888", got_data[0]); end
    n_tests++; if (got_data[1] !== 64'h9999) begin n_fail++; $display("FAIL mrst_new1: got %h expected 9999", got_data[1]); end
    n_tests++; if (got_last[1] !== 1'b1) begin n_fail++; $display("FAIL mrst_new_last: got %b expected 1", got_last[1]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_ar(64'h18, 8'd1, 3'd3, 2'd1, ok);
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = 64'h50;
    s_axi_arlen   = 8'd0;
    s_axi_arsize  = 3'd3;
    s_axi_arburst = 2'd1;
    collect(2, 0);
    n_tests++; if (ar_high !== 0) begin n_fail++; $display("FAIL b2b_arready_busy: got %0d high cycles expected 0", ar_high); end
    n_tests++; if (got_data[0] !== 64'h3333) begin n_fail++; $display("FAIL b2b_first0: got %h expected 3333", got_data[0]); end
    n_tests++; if (got_data[1] !== 64'h4444) begin n_fail++; $display("FAIL b2b_first1: got %h expected 4444", got_data[1]); end
    n_tests++; if (s_axi_arready !== 1'b1) begin n_fail++; $display("FAIL b2b_arready_reopen: got %b expected 1", s_axi_arready); end
    tick();
    s_axi_arvalid = 1'b0;
    n_tests++; if (s_axi_arready !== 1'b0) begin n_fail++; $display("FAIL b2b_arready_drop: got %b expected 0", s_axi_arready); end
    collect(1, 0);
    n_tests++; if (first_cyc !== 2) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 2", first_cyc); end
    n_tests++; if (got_data[0] !== 64'hAAAA) begin n_fail++; $display("FAIL b2b_second: got %h expected aaaa", got_data[0]); end
    n_tests++; if (got_last[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_last: got %b expected 1", got_last[0]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_wrap();
    test_incr_stall();
    test_decerr();
    test_bad_wrap();
    test_fixed();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
